dm_fetch_responder: RTL and testbench
=====================================

Name: dm_fetch_responder

Overview:
Debug-module side of the core instruction-fetch interface: the responder for fetches the core issues after jumping to DmHaltAddr or DmExceptionAddr.
- Accepts fetch requests, returns park-loop instruction words in order, and reports debug-mode exceptions to the debug module.
- Sits between the core's debug instruction port and the debug module's status logic.
- Parameters are set from the same DmHaltAddr/DmExceptionAddr values passed down to the core.

Parameters:
DmHaltAddr, 32'h0000_0800, debug halt entry address (word-aligned)
DmExceptionAddr, 32'h0000_0808, debug exception entry address (word-aligned)
MaxOutstanding, 2, response queue depth; legal range 1..4
RespDelay, 1, cycles from an entry reaching queue head to its rvalid; legal range 1..4

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i
instr_req_i  in  1  fetch request
instr_addr_i  in  32  fetch address
instr_gnt_o  out  1  request granted this cycle
instr_rvalid_o  out  1  response valid, single-cycle pulse per response
instr_rdata_o  out  32  response instruction word
instr_err_o  out  1  response error, qualified by instr_rvalid_o
dm_exception_o  out  1  sticky: an exception-address fetch has been responded
dm_exception_clr_i  in  1  clears dm_exception_o
exc_count_o  out  8  saturating count of exception-address responses

Behaviour:
- Reset (rst_ni=0 at a clock edge): queue emptied; countdown cleared; all outputs 0; exc_count_o=0. Requests pending at reset are dropped and never answered.
- Address decode uses instr_addr_i[31:2] only:
  - Match DmHaltAddr[31:2] -> class HALT.
  - Match DmExceptionAddr[31:2] -> class EXC.
  - Otherwise -> class UNMAPPED.
  - If both parameters decode to the same word, EXC wins.
- Grant:
  - instr_gnt_o = instr_req_i && (count < MaxOutstanding).
  - Combinational; count is the registered queue occupancy.
  - A pop in the same cycle does not free a slot until the next cycle.
- On each grant, push the decoded class into an in-order FIFO of depth MaxOutstanding.
- Head countdown:
  - Loaded with RespDelay when an entry becomes head: pushed into an empty queue, or exposed by a pop.
  - Decrements each cycle while the queue is non-empty.
  - At value 1, the head pops next cycle with instr_rvalid_o=1.
  - Minimum grant-to-rvalid latency is RespDelay cycles; with RespDelay=1, rvalid is asserted the cycle after the grant.
- Response data:
  - HALT: rdata=32'h0000_006F (jal x0,0), err=0.
  - EXC: rdata=32'h0000_006F, err=0; dm_exception_o set, exc_count_o increments, saturating at 8'hFF.
  - UNMAPPED: see Optional Feature.
  - When rvalid=0: rdata=0, err=0.
- Push and pop in the same cycle: count unchanged. FIFO pointers wrap modulo MaxOutstanding.
- dm_exception_clr_i:
  - Clears dm_exception_o next cycle.
  - If asserted in the same cycle as an EXC response, set wins and dm_exception_o stays 1.
  - Does not clear exc_count_o.
- No back-pressure on responses: the core always accepts rvalid.

Optional Feature:
Macro DM_FETCH_UNMAPPED_ERR_EN.
- Defined: UNMAPPED responses return rdata=0, err=1.
- Undefined: UNMAPPED responses return rdata=32'h0000_0013 (nop), err=0.
- Queue timing and occupancy are identical in both builds.

Test Plan:
- Reset then single HALT fetch: req=1, addr=32'h800 for one cycle, RespDelay=1 -> gnt same cycle; next cycle rvalid=1, rdata=32'h0000006F, err=0; dm_exception_o stays 0.
- EXC fetch at addr=32'h80A (byte offset ignored) -> one response with rdata=32'h6F, dm_exception_o=1, exc_count_o=1. Pulse clr -> dm_exception_o=0, count stays 1.
- Queue-full back-to-back, MaxOutstanding=2, RespDelay=3, req held with addrs 800,808,800:
  - Two grants on consecutive cycles; third gnt held at 0 until the cycle after the first rvalid.
  - Responses arrive in order HALT, EXC, HALT, 3 cycles apart.
- Unmapped addr=32'h1000:
  - With DM_FETCH_UNMAPPED_ERR_EN -> rvalid with err=1, rdata=0.
  - Without the macro -> err=0, rdata=32'h00000013.
- Reset mid-operation: two grants outstanding, rst_ni=0 for one cycle -> no rvalid after reset; count=0; gnt available again next cycle.
- Saturation: 260 EXC fetches -> exc_count_o=8'hFF. Clr asserted in the same cycle as an EXC response -> dm_exception_o remains 1.

Source files
------------

// File: rtl/dm_fetch_responder.sv
// Debug-module responder for core instruction fetches to the halt and exception entry points.
// Build option DM_FETCH_UNMAPPED_ERR_EN: unmapped fetches return an error instead of a nop.
module dm_fetch_responder #(
    parameter logic [31:0] DmHaltAddr      = 32'h0000_0800,
    parameter logic [31:0] DmExceptionAddr = 32'h0000_0808,
    parameter int unsigned MaxOutstanding  = 2,
    parameter int unsigned RespDelay       = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    output logic        dm_exception_o,
    input  logic        dm_exception_clr_i,
    output logic [7:0]  exc_count_o
);

    typedef enum logic [1:0] {
        CLS_HALT,
        CLS_EXC,
        CLS_UNMAPPED
    } fetch_class_e;

    localparam logic [2:0]  MAX_OUT  = 3'(MaxOutstanding);
    localparam logic [2:0]  DELAY    = 3'(RespDelay);
    localparam logic [1:0]  LAST_PTR = 2'(MaxOutstanding - 1);
    localparam logic [31:0] JAL_SELF = 32'h0000_006F;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    fetch_class_e fifo_q [4];
    logic [1:0]   wr_ptr_q;
    logic [1:0]   rd_ptr_q;
    logic [2:0]   count_q;
    logic [2:0]   countdown_q;
    logic         exc_flag_q;
    logic [7:0]   exc_count_q;

    fetch_class_e req_class;
    fetch_class_e head_class;
    logic         push;
    logic         pop;
    logic         head_is_exc;
    logic         unused_addr_bits;

    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        return (ptr == LAST_PTR) ? 2'd0 : ptr + 2'd1;
    endfunction

    assign unused_addr_bits = ^instr_addr_i[1:0];

    // Exception address is checked first so it wins when both entry points share a word.
    always_comb begin
        req_class = CLS_UNMAPPED;
        if (instr_addr_i[31:2] == DmExceptionAddr[31:2]) begin
            req_class = CLS_EXC;
        end else if (instr_addr_i[31:2] == DmHaltAddr[31:2]) begin
            req_class = CLS_HALT;
        end
    end

    assign push        = instr_req_i && (count_q < MAX_OUT);
    assign pop         = (count_q != 3'd0) && (countdown_q == 3'd1);
    assign head_class  = fifo_q[rd_ptr_q];
    assign head_is_exc = pop && (head_class == CLS_EXC);

    assign instr_gnt_o    = push;
    assign instr_rvalid_o = pop;
    assign dm_exception_o = exc_flag_q;
    assign exc_count_o    = exc_count_q;

    always_comb begin
        instr_rdata_o = 32'h0;
        instr_err_o   = 1'b0;
        if (pop) begin
            case (head_class)
                CLS_HALT: instr_rdata_o = JAL_SELF;
                CLS_EXC:  instr_rdata_o = JAL_SELF;
                default: begin
`ifdef DM_FETCH_UNMAPPED_ERR_EN
                    instr_rdata_o = 32'h0;
                    instr_err_o   = 1'b1;
`else
                    instr_rdata_o = NOP;
                    instr_err_o   = 1'b0;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= req_class;
        end
    end

    // Countdown reloads whenever a new entry becomes head, so a pop never frees its slot early.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            countdown_q <= 3'd0;
            exc_flag_q  <= 1'b0;
            exc_count_q <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase

            if (pop) begin
                countdown_q <= ((count_q > 3'd1) || push) ? DELAY : 3'd0;
            end else if (count_q == 3'd0) begin
                countdown_q <= push ? DELAY : 3'd0;
            end else begin
                countdown_q <= countdown_q - 3'd1;
            end

            if (head_is_exc) begin
                exc_flag_q <= 1'b1;
            end else if (dm_exception_clr_i) begin
                exc_flag_q <= 1'b0;
            end

            if (head_is_exc && (exc_count_q != 8'hFF)) begin
                exc_count_q <= exc_count_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dm_fetch_responder.sv
// Self-checking bench: two responder instances (fast and slow response) against a queue-level model.
module tb_dm_fetch_responder;

    localparam int M_A = 2;
    localparam int R_A = 1;
    localparam int M_B = 2;
    localparam int R_B = 3;
    localparam logic [31:0] HALT_ADDR = 32'h0000_0800;
    localparam logic [31:0] EXC_ADDR  = 32'h0000_0808;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [31:0] addr_a = 32'h0;
    logic [31:0] addr_b = 32'h0;

    logic        gnt_a, rvalid_a, err_a, exc_a;
    logic        gnt_b, rvalid_b, err_b, exc_b;
    logic [31:0] rdata_a, rdata_b;
    logic [7:0]  cnt_a, cnt_b;

    always #5 clk = ~clk;

    dm_fetch_responder #(
        .DmHaltAddr(HALT_ADDR), .DmExceptionAddr(EXC_ADDR),
        .MaxOutstanding(M_A), .RespDelay(R_A)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(req_a), .instr_addr_i(addr_a),
        .instr_gnt_o(gnt_a), .instr_rvalid_o(rvalid_a),
        .instr_rdata_o(rdata_a), .instr_err_o(err_a),
        .dm_exception_o(exc_a), .dm_exception_clr_i(clr),
        .exc_count_o(cnt_a)
    );

    dm_fetch_responder #(
        .DmHaltAddr(HALT_ADDR), .DmExceptionAddr(EXC_ADDR),
        .MaxOutstanding(M_B), .RespDelay(R_B)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(req_b), .instr_addr_i(addr_b),
        .instr_gnt_o(gnt_b), .instr_rvalid_o(rvalid_b),
        .instr_rdata_o(rdata_b), .instr_err_o(err_b),
        .dm_exception_o(exc_b), .dm_exception_clr_i(clr),
        .exc_count_o(cnt_b)
    );

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    bit model_on = 1'b0;

    // Model: each entry remembers its grant cycle; it answers RespDelay cycles after
    // the later of its grant and the previous response.
    int max_out [2] = '{M_A, M_B};
    int resp_delay [2] = '{R_A, R_B};
    int q_cls [2][4];
    int q_gcyc [2][4];
    int q_size [2] = '{0, 0};
    int last_pop [2] = '{-1000, -1000};
    bit m_exc [2] = '{1'b0, 1'b0};
    int m_cnt [2] = '{0, 0};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int classOf(input logic [31:0] a);
        if (a[31:2] == EXC_ADDR[31:2]) return 1;
        if (a[31:2] == HALT_ADDR[31:2]) return 0;
        return 2;
    endfunction

    task automatic modelCycle(input int d, input logic gnt, input logic rv, input logic [31:0] rdata,
                              input logic err, input logic exc, input logic [7:0] cnt,
                              input logic req, input logic [31:0] addr);
        int due;
        int hc;
        logic e_gnt;
        logic e_rv;
        logic [31:0] e_data;
        logic e_err;
        string sfx;
        sfx = (d == 0) ? "a" : "b";
        e_gnt = req && (q_size[d] < max_out[d]);
        e_rv = 1'b0;
        hc = 0;
        if (q_size[d] > 0) begin
            due = ((q_gcyc[d][0] > last_pop[d]) ? q_gcyc[d][0] : last_pop[d]) + resp_delay[d];
            e_rv = (cyc == due);
            hc = q_cls[d][0];
        end
        e_data = 32'h0;
        e_err = 1'b0;
        if (e_rv) begin
            if (hc == 2) begin
`ifdef DM_FETCH_UNMAPPED_ERR_EN
                e_err = 1'b1;
`else
                e_data = 32'h0000_0013;
`endif
            end else begin
                e_data = 32'h0000_006F;
            end
        end
        if (model_on) begin
            checkOutput({"gnt_", sfx}, 32'(gnt), 32'(e_gnt));
            checkOutput({"rvalid_", sfx}, 32'(rv), 32'(e_rv));
            checkOutput({"rdata_", sfx}, rdata, e_data);
            checkOutput({"err_", sfx}, 32'(err), 32'(e_err));
            checkOutput({"dm_exception_", sfx}, 32'(exc), 32'(m_exc[d]));
            checkOutput({"exc_count_", sfx}, 32'(cnt), 32'(m_cnt[d]));
        end
        if (!rst_n) begin
            q_size[d] = 0;
            last_pop[d] = -1000;
            m_exc[d] = 1'b0;
            m_cnt[d] = 0;
        end else begin
            if (e_rv) begin
                for (int i = 0; i < 3; i++) begin
                    q_cls[d][i] = q_cls[d][i+1];
                    q_gcyc[d][i] = q_gcyc[d][i+1];
                end
                q_size[d]--;
                last_pop[d] = cyc;
                if (hc == 1 && m_cnt[d] < 255) m_cnt[d]++;
            end
            if (e_rv && hc == 1) m_exc[d] = 1'b1;
            else if (clr) m_exc[d] = 1'b0;
            if (e_gnt) begin
                q_cls[d][q_size[d]] = classOf(addr);
                q_gcyc[d][q_size[d]] = cyc;
                q_size[d]++;
            end
        end
    endtask

    always @(negedge clk) begin
        modelCycle(0, gnt_a, rvalid_a, rdata_a, err_a, exc_a, cnt_a, req_a, addr_a);
        modelCycle(1, gnt_b, rvalid_b, rdata_b, err_b, exc_b, cnt_b, req_b, addr_b);
        cyc++;
    end

    task automatic applyStimulus(input logic ra, input logic [31:0] aa, input logic rb,
                                 input logic [31:0] ab, input logic c, input logic rst);
        @(posedge clk);
        #1;
        req_a = ra;
        addr_a = aa;
        req_b = rb;
        addr_b = ab;
        clr = c;
        rst_n = rst;
    endtask

    initial begin
        logic [31:0] tbl [3];
        logic [10:0] gnt_bits;
        logic [10:0] rv_bits;
        int idx;
        logic [31:0] ra_addr;
        tbl = '{32'h800, 32'h808, 32'h800};

        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        model_on = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 1);
        #2;
        checkOutput("reset_exc_count", 32'(cnt_a), 32'h0);
        checkOutput("reset_dm_exception", 32'(exc_a), 32'h0);
        checkOutput("reset_rvalid", 32'(rvalid_b), 32'h0);

        // Single halt fetch on the fast instance
        applyStimulus(1, 32'h800, 0, 0, 0, 1);
        #2 checkOutput("halt_gnt", 32'(gnt_a), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        #2;
        checkOutput("halt_rvalid", 32'(rvalid_a), 32'h1);
        checkOutput("halt_rdata", rdata_a, 32'h0000_006F);
        checkOutput("halt_err", 32'(err_a), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        #2 checkOutput("halt_no_exc", 32'(exc_a), 32'h0);

        // Exception fetch with a byte offset, then clear
        applyStimulus(1, 32'h80A, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        #2;
        checkOutput("exc_rvalid", 32'(rvalid_a), 32'h1);
        checkOutput("exc_rdata", rdata_a, 32'h0000_006F);
        applyStimulus(0, 0, 0, 0, 0, 1);
        #2;
        checkOutput("exc_flag_set", 32'(exc_a), 32'h1);
        checkOutput("exc_count_one", 32'(cnt_a), 32'h1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        #2;
        checkOutput("exc_flag_cleared", 32'(exc_a), 32'h0);
        checkOutput("exc_count_kept", 32'(cnt_a), 32'h1);

        // Unmapped fetch
        applyStimulus(1, 32'h1000, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        #2;
        checkOutput("unmapped_rvalid", 32'(rvalid_a), 32'h1);
`ifdef DM_FETCH_UNMAPPED_ERR_EN
        checkOutput("unmapped_err", 32'(err_a), 32'h1);
        checkOutput("unmapped_rdata", rdata_a, 32'h0);
`else
        checkOutput("unmapped_err", 32'(err_a), 32'h0);
        checkOutput("unmapped_rdata", rdata_a, 32'h0000_0013);
`endif

        // Queue-full back-to-back on the slow instance
        idx = 0;
        for (int c = 0; c < 11; c++) begin
            applyStimulus(0, 0, (idx < 3), tbl[(idx < 3) ? idx : 0], 0, 1);
            #2;
            gnt_bits[c] = gnt_b;
            rv_bits[c] = rvalid_b;
            if (rvalid_b) checkOutput("full_rdata", rdata_b, 32'h0000_006F);
            if (gnt_b) idx++;
        end
        checkOutput("full_gnt_pattern", 32'(gnt_bits), 32'(11'b00000010011));
        checkOutput("full_rvalid_pattern", 32'(rv_bits), 32'(11'b01001001000));
        applyStimulus(0, 0, 0, 0, 0, 1);
        #2;
        checkOutput("full_exc_count", 32'(cnt_b), 32'h1);
        checkOutput("full_exc_flag", 32'(exc_b), 32'h1);

        // Reset with two fetches outstanding
        applyStimulus(0, 0, 1, 32'h800, 0, 1);
        applyStimulus(0, 0, 1, 32'h808, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h800, 0, 1);
        #2;
        checkOutput("post_reset_gnt", 32'(gnt_b), 32'h1);
        checkOutput("post_reset_rvalid0", 32'(rvalid_b), 32'h0);
        checkOutput("post_reset_count", 32'(cnt_b), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        #2 checkOutput("post_reset_rvalid1", 32'(rvalid_b), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        #2 checkOutput("post_reset_rvalid2", 32'(rvalid_b), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        #2 checkOutput("post_reset_new_rvalid", 32'(rvalid_b), 32'h1);

        // Saturation of the exception counter
        for (int i = 0; i < 260; i++) applyStimulus(1, 32'h808, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        #2 checkOutput("sat_exc_count", 32'(cnt_a), 32'hFF);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        #2 checkOutput("sat_flag_cleared", 32'(exc_a), 32'h0);
        applyStimulus(1, 32'h808, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        #2 checkOutput("set_vs_clr_rvalid", 32'(rvalid_a), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        #2;
        checkOutput("set_wins_over_clr", 32'(exc_a), 32'h1);
        checkOutput("sat_count_held", 32'(cnt_a), 32'hFF);

        // Randomized traffic on both instances
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ab;
            case ($urandom_range(0, 5))
                0: ra_addr = 32'h800;
                1: ra_addr = 32'h808;
                2: ra_addr = 32'h800 | 32'($urandom_range(0, 3));
                3: ra_addr = 32'h808 | 32'($urandom_range(0, 3));
                4: ra_addr = 32'h1000;
                default: ra_addr = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: ab = 32'h800;
                1: ab = 32'h80B;
                2: ab = 32'h804;
                default: ab = $urandom;
            endcase
            applyStimulus(($urandom_range(0, 9) < 6), ra_addr, ($urandom_range(0, 9) < 5), ab,
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) != 0));
        end
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 1);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
